pattern_sequencer: RTL
======================

# pattern_sequencer

Multi-channel step sequencer: records an on/off pattern per step into an internal step memory, then replays it in a timed loop on parallel outputs. Generalises the two-button/two-LED board sequencer to N channels, programmable depth and step period, adds explicit record/play modes and a memory clear. It sits between debounced button inputs and LED/GPIO drivers in the top level.

## Interface
- NUM_CHANNELS, 2: pattern width, bits per step (≥1)
- NUM_STEPS, 8: steps in the loop (≥2)
- STEP_COUNTS, 6_000_000: clk cycles per step in play mode (≥2)
- clk  in  1  system clock (12 MHz on board)
- rst  in  1  asynchronous, active-high reset
- rec  in  1  level; 1 = record mode, 0 = play mode (synchronous, debounced)
- set  in  1  level; rising edge stores ptn at current step (record mode only)
- clear  in  1  level; rising edge zeroes the whole step memory
- ptn  in  NUM_CHANNELS  live pattern input
- out  out  NUM_CHANNELS  sequencer output
- step_idx  out  $clog2(NUM_STEPS)  current step pointer
- busy  out  1  high while clearing

## Operation
- States: CLEAR, PLAY, REC.
- Reset: state=CLEAR, step_idx=0, out=0, busy=1, timer=0, edge registers=0. Memory is not reset directly; the forced CLEAR zeroes it.
- CLEAR: writes 0 to mem[step_idx] each cycle, step_idx 0→NUM_STEPS-1 (NUM_STEPS cycles). After the last write: step_idx=0, timer=0, busy=0, next state REC if rec=1 else PLAY. rec/set/clear ignored in CLEAR.
- PLAY: timer counts 0..STEP_COUNTS-1; at terminal count timer→0 and step_idx advances (wrap NUM_STEPS-1→0). out = mem[step_idx], registered.
- REC: timer held at 0. Rising edge of set (set & ~set_d) writes ptn to mem[step_idx], step_idx advances with wrap. out = ptn, registered.
- Mode change (rec differs from current PLAY/REC): next state follows rec, step_idx=0, timer=0.
- Priority per cycle: clear edge > mode change > set edge > timer tick. A set edge coinciding with a mode change or clear is dropped (no write).
- clear edge from PLAY/REC: enter CLEAR with step_idx=0, busy=1 next cycle.
- Edge detectors sample set/clear every cycle in every state, so a level held high through CLEAR does not retrigger on exit.
- Widths: timer $clog2(STEP_COUNTS) bits; all wraps by explicit compare, never by natural overflow (NUM_STEPS need not be a power of two).

## Timing
- Play read latency: out shows mem[k] one cycle after step_idx becomes k.
- Step period in PLAY: exactly STEP_COUNTS cycles; first advance STEP_COUNTS cycles after entering PLAY.
- Record: write and step_idx increment on the clock edge where the set edge is detected; out follows ptn with one-cycle latency.
- Clear: busy high for exactly NUM_STEPS cycles (reset-initiated or edge-initiated); out=0 throughout.
- Reset asserted mid-operation: all outputs return to reset values immediately (async); clear restarts from step 0 on deassertion.

## Configuration
- PATTERN_SEQUENCER_PINGPONG_EN defined: PLAY runs 0→NUM_STEPS-1→0, each endpoint played once per turn (period 2·NUM_STEPS−2 steps); one direction register, reset to forward and set to forward on every entry to PLAY. REC and CLEAR unchanged.
- Undefined: PLAY wraps NUM_STEPS-1→0; no direction logic.

## Structure
- Package seq_pkg: state encoding (CLEAR, PLAY, REC) and the width-calc helper shared by the top and the timer.
- Sub-module seq_step_timer: prescaler with clear input and one-cycle tick at terminal count, parametrised by STEP_COUNTS.
- Step memory inferred in the top as NUM_STEPS × NUM_CHANNELS array, synchronous write/read (block-RAM friendly).

## Test plan
(NUM_CHANNELS=2, NUM_STEPS=8, STEP_COUNTS=10)
- Pulse rst → out=0, busy=1 for 8 cycles, then state PLAY, step_idx=0, out=0 through two full loops.
- rec=1, ptn=01, set pulses ×3 with ptn 01,10,11 → mem[0..2]=01,10,11, step_idx=3; rec=0 → out sequence 01,10,11,00×5 at 10-cycle spacing, repeating.
- Record 8 set pulses → step_idx wraps to 0; a 9th write overwrites mem[0].
- set edge in same cycle as rec falling → no write, step_idx=0, PLAY.
- clear edge mid-PLAY → busy 8 cycles, all steps read 00 after; clear held high during CLEAR causes no second clear.
- With PATTERN_SEQUENCER_PINGPONG_EN: step_idx 0..7,6..1,0..., each held 10 cycles; rst mid-loop → step_idx=0, out=0 immediately.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared state encoding and width helper for pattern_sequencer and its step timer.
package seq_pkg;

  // state    | meaning
  // ST_CLEAR | zeroing step memory, busy high
  // ST_PLAY  | timed replay of the step memory
  // ST_REC   | set edges store ptn at the step pointer
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PLAY  = 2'd1,
    ST_REC   = 2'd2
  } seq_state_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Step prescaler: counts 0..STEP_COUNTS-1 while enabled, one-cycle tick at terminal count.
module seq_step_timer
  import seq_pkg::*;
#(
  parameter int unsigned STEP_COUNTS = 6_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = width_of(STEP_COUNTS);
  localparam logic [CNT_W-1:0] TC = CNT_W'(STEP_COUNTS - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TC) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Multi-channel step sequencer: record per-step patterns, replay them in a timed loop.
// Optional PATTERN_SEQUENCER_PINGPONG_EN: replay bounces 0..N-1..0 instead of wrapping.
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned NUM_STEPS    = 8,
  parameter int unsigned STEP_COUNTS  = 6_000_000,
  localparam int unsigned IDX_W       = width_of(NUM_STEPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rec,
  input  logic                    set,
  input  logic                    clear,
  input  logic [NUM_CHANNELS-1:0] ptn,
  output logic [NUM_CHANNELS-1:0] out,
  output logic [IDX_W-1:0]        step_idx,
  output logic                    busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STEPS - 1);

  seq_state_t state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] idx_inc;
  logic [NUM_CHANNELS-1:0] mem [NUM_STEPS];
  logic [NUM_CHANNELS-1:0] wdata;
  logic we;
  logic set_d, clear_d;
  logic set_rise, clear_rise;
  logic timer_clr, tick;
`ifdef PATTERN_SEQUENCER_PINGPONG_EN
  logic dir, dir_n;
`endif

  assign set_rise   = set & ~set_d;
  assign clear_rise = clear & ~clear_d;
  assign idx_inc    = (step_idx == LAST) ? '0 : step_idx + IDX_W'(1);
  assign busy       = (state == ST_CLEAR);

  seq_step_timer #(.STEP_COUNTS(STEP_COUNTS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (state == ST_PLAY),
    .tick (tick)
  );

  always_comb begin
    state_n   = state;
    idx_n     = step_idx;
    we        = 1'b0;
    wdata     = ptn;
    timer_clr = 1'b0;
`ifdef PATTERN_SEQUENCER_PINGPONG_EN
    dir_n     = dir;
`endif
    case (state)
      ST_CLEAR: begin
        we        = 1'b1;
        wdata     = '0;
        timer_clr = 1'b1;
        if (step_idx == LAST) begin
          idx_n   = '0;
          state_n = rec ? ST_REC : ST_PLAY;
        end else begin
          idx_n = idx_inc;
        end
      end
      ST_PLAY, ST_REC: begin
        if (clear_rise) begin
          state_n   = ST_CLEAR;
          idx_n     = '0;
          timer_clr = 1'b1;
        end else if (rec != (state == ST_REC)) begin
          state_n   = rec ? ST_REC : ST_PLAY;
          idx_n     = '0;
          timer_clr = 1'b1;
        end else if (state == ST_REC) begin
          timer_clr = 1'b1;
          if (set_rise) begin
            we    = 1'b1;
            idx_n = idx_inc;
          end
        end else if (tick) begin
`ifdef PATTERN_SEQUENCER_PINGPONG_EN
          if (dir) begin
            if (step_idx == LAST) begin
              idx_n = step_idx - IDX_W'(1);
              dir_n = 1'b0;
            end else begin
              idx_n = step_idx + IDX_W'(1);
            end
          end else begin
            if (step_idx == '0) begin
              idx_n = IDX_W'(1);
              dir_n = 1'b1;
            end else begin
              idx_n = step_idx - IDX_W'(1);
            end
          end
`else
          idx_n = idx_inc;
`endif
        end
      end
      default: begin
        state_n = ST_CLEAR;
        idx_n   = '0;
      end
    endcase
`ifdef PATTERN_SEQUENCER_PINGPONG_EN
    if (state_n == ST_PLAY && state != ST_PLAY) dir_n = 1'b1;
`endif
  end

  // Output is forced low on the edge entering CLEAR so busy and out=0 line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      step_idx <= '0;
      out      <= '0;
      set_d    <= 1'b0;
      clear_d  <= 1'b0;
    end else begin
      state    <= state_n;
      step_idx <= idx_n;
      set_d    <= set;
      clear_d  <= clear;
      if (state_n == ST_CLEAR || state == ST_CLEAR) out <= '0;
      else if (state == ST_REC)                      out <= ptn;
      else                                           out <= mem[step_idx];
    end
  end

`ifdef PATTERN_SEQUENCER_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= 1'b1;
    else     dir <= dir_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (we) mem[step_idx] <= wdata;
  end

endmodule
